uart_rx_frame_chk: RTL and testbench

//  Parametrised UART RX frame checker: the successor to the combinational start-bit check.

---
 rtl/uart_rx_frame_chk.sv | 176 +++++++++++++++++
 tb/tb_uart_rx_frame_chk.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_chk.sv
// UART RX frame checker.
// Tracks one frame per frm_start, consuming one sampled bit per bit_vld strobe.
// Checks the start bit, optional parity and 1/2 stop bits, and deshifts data LSB-first.
// Clean frames publish p_data with a data_vld pulse. Bad frames raise a registered error pulse.
// Every output pulse lands exactly one clock after the bit_vld that completes the frame.

module uart_rx_frame_chk #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned STOP_BITS  = 1,
   parameter logic        START_BIT  = 1'b0,
   parameter logic        STOP_BIT   = 1'b1
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  frm_start,
   input  logic                  bit_vld,
   input  logic                  sampled_bit,
   input  logic                  par_en,
   input  logic                  par_typ,
   output logic [DATA_WIDTH-1:0] p_data,
   output logic                  data_vld,
   output logic                  strt_glitch,
   output logic                  par_err,
   output logic                  stop_err,
   output logic                  busy
);

   // One counter serves both the data bits and the stop bits.
   localparam int unsigned    CNT_W     = $clog2(DATA_WIDTH);
   localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_WIDTH - 1);
   localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_e;

   state_e                  state_q,       state_d;
   logic [DATA_WIDTH-1:0]   shift_q,       shift_d;
   logic [CNT_W-1:0]        cnt_q,         cnt_d;
   logic                    par_en_q,      par_en_d;
   logic                    par_typ_q,     par_typ_d;
   logic                    par_flag_q,    par_flag_d;
   logic                    stop_flag_q,   stop_flag_d;
   logic [DATA_WIDTH-1:0]   p_data_q,      p_data_d;
   logic                    data_vld_q,    data_vld_d;
   logic                    strt_glitch_q, strt_glitch_d;
   logic                    par_err_q,     par_err_d;
   logic                    stop_err_q,    stop_err_d;
   logic                    exp_par;

   // State register and all registered outputs; reset wins over everything, discarding any partial frame.
   always_ff @(posedge CLK) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (RST) begin
         state_q       <= S_IDLE;
         shift_q       <= '0;
         cnt_q         <= '0;
         par_en_q      <= 1'b0;
         par_typ_q     <= 1'b0;
         par_flag_q    <= 1'b0;
         stop_flag_q   <= 1'b0;
         p_data_q      <= '0;
         data_vld_q    <= 1'b0;
         strt_glitch_q <= 1'b0;
         par_err_q     <= 1'b0;
         stop_err_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         shift_q       <= shift_d;
         cnt_q         <= cnt_d;
         par_en_q      <= par_en_d;
         par_typ_q     <= par_typ_d;
         par_flag_q    <= par_flag_d;
         stop_flag_q   <= stop_flag_d;
         p_data_q      <= p_data_d;
         data_vld_q    <= data_vld_d;
         strt_glitch_q <= strt_glitch_d;
         par_err_q     <= par_err_d;
         stop_err_q    <= stop_err_d;
      end
   end

   // Next-state logic: frame sequencing, deshifting, error accumulation and frame-end pulses.
   always_comb begin
      // NOTE: every signal gets a default first, so no path through the case can infer a latch.
      state_d       = state_q;
      shift_d       = shift_q;
      cnt_d         = cnt_q;
      par_en_d      = par_en_q;
      par_typ_d     = par_typ_q;
      par_flag_d    = par_flag_q;
      stop_flag_d   = stop_flag_q;
      p_data_d      = p_data_q;
      data_vld_d    = 1'b0;
      strt_glitch_d = 1'b0;
      par_err_d     = 1'b0;
      stop_err_d    = 1'b0;
      exp_par       = par_typ_q ? ~^shift_q : ^shift_q;

      unique case (state_q)
         S_IDLE: begin
            // bit_vld is deliberately ignored here, even in the same cycle as frm_start.
            if (frm_start) begin
               par_en_d    = par_en;
               par_typ_d   = par_typ;
               par_flag_d  = 1'b0;
               stop_flag_d = 1'b0;
               cnt_d       = '0;
               state_d     = S_START;
            end
         end
         S_START: begin
            if (bit_vld) begin
               if (sampled_bit == START_BIT) begin
                  state_d = S_DATA;
               end else begin
                  strt_glitch_d = 1'b1;
                  state_d       = S_IDLE;
               end
            end
         end
         S_DATA: begin
            if (bit_vld) begin
               // Bits enter at the top, so the first data bit ends up at bit 0.
               shift_d = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
               if (cnt_q == LAST_DATA) begin
                  cnt_d   = '0;
                  state_d = par_en_q ? S_PARITY : S_STOP;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         S_PARITY: begin
            if (bit_vld) begin
               if (sampled_bit != exp_par) begin
                  par_flag_d = 1'b1;
               end
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (bit_vld) begin
               stop_flag_d = stop_flag_q | (sampled_bit != STOP_BIT);
               if (cnt_q == LAST_STOP) begin
                  // Frame end: report errors, publish data only when the frame is clean.
                  state_d    = S_IDLE;
                  par_err_d  = par_flag_q;
                  stop_err_d = stop_flag_d;
                  if (!par_flag_q && !stop_flag_d) begin
                     data_vld_d = 1'b1;
                     p_data_d   = shift_q;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign p_data      = p_data_q;
   assign data_vld    = data_vld_q;
   assign strt_glitch = strt_glitch_q;
   assign par_err     = par_err_q;
   assign stop_err    = stop_err_q;
   assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_frame_chk.sv
// Bench for uart_rx_frame_chk: one instance with one stop bit, one with two stop bits.
// Expected frame outcomes are queued when the final bit is driven and popped when a pulse appears.

module tb_uart_rx_frame_chk;

   logic            CLK = 1'b0;
   logic            RST;
   logic [1:0]      frm_start, bit_vld, sampled_bit, par_en, par_typ;
   logic [1:0][7:0] p_data;
   logic [1:0]      data_vld, strt_glitch, par_err, stop_err, busy;

   typedef struct {
      logic       dv;
      logic       sg;
      logic       pe;
      logic       se;
      logic [7:0] pd;
      int         cyc;
   } exp_t;

   exp_t            sb0[$];
   exp_t            sb1[$];
   exp_t            e0, e1;
   logic [1:0][7:0] last_good;
   int              sel;
   int              cyc = 0;
   int              n_chk = 0;
   int              n_err = 0;

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   uart_rx_frame_chk #(.DATA_WIDTH(8), .STOP_BITS(1)) dut0 (
      .CLK(CLK), .RST(RST),
      .frm_start(frm_start[0]), .bit_vld(bit_vld[0]), .sampled_bit(sampled_bit[0]),
      .par_en(par_en[0]), .par_typ(par_typ[0]),
      .p_data(p_data[0]), .data_vld(data_vld[0]), .strt_glitch(strt_glitch[0]),
      .par_err(par_err[0]), .stop_err(stop_err[0]), .busy(busy[0])
   );

   uart_rx_frame_chk #(.DATA_WIDTH(8), .STOP_BITS(2)) dut1 (
      .CLK(CLK), .RST(RST),
      .frm_start(frm_start[1]), .bit_vld(bit_vld[1]), .sampled_bit(sampled_bit[1]),
      .par_en(par_en[1]), .par_typ(par_typ[1]),
      .p_data(p_data[1]), .data_vld(data_vld[1]), .strt_glitch(strt_glitch[1]),
      .par_err(par_err[1]), .stop_err(stop_err[1]), .busy(busy[1])
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic cmp_out(input int d, input exp_t e);
      check($sformatf("data_vld%0d", d),    32'(data_vld[d]),    32'(e.dv));
      check($sformatf("strt_glitch%0d", d), 32'(strt_glitch[d]), 32'(e.sg));
      check($sformatf("par_err%0d", d),     32'(par_err[d]),     32'(e.pe));
      check($sformatf("stop_err%0d", d),    32'(stop_err[d]),    32'(e.se));
      check($sformatf("p_data%0d", d),      32'(p_data[d]),      32'(e.pd));
      check($sformatf("latency%0d", d),     32'(cyc),            32'(e.cyc));
   endtask

   // Monitor: any output pulse must match the oldest queued expectation.
   always @(negedge CLK) begin
      if (!RST) begin
         if (data_vld[0] | strt_glitch[0] | par_err[0] | stop_err[0]) begin
            if (sb0.size() == 0) begin
               check("spurious0", {28'b0, data_vld[0], strt_glitch[0], par_err[0], stop_err[0]}, 32'd0);
            end else begin
               e0 = sb0.pop_front();
               cmp_out(0, e0);
            end
         end
         if (data_vld[1] | strt_glitch[1] | par_err[1] | stop_err[1]) begin
            if (sb1.size() == 0) begin
               check("spurious1", {28'b0, data_vld[1], strt_glitch[1], par_err[1], stop_err[1]}, 32'd0);
            end else begin
               e1 = sb1.pop_front();
               cmp_out(1, e1);
            end
         end
      end
   end

   // Drives one bit after a random gap; the final bit of a frame queues its expected outcome.
   task automatic send_bit(input logic b, input int gap, input bit last, input exp_t e);
      repeat ($urandom_range(gap, 0)) @(negedge CLK);
      bit_vld[sel]     = 1'b1;
      sampled_bit[sel] = b;
      if (last) begin
         e.cyc = cyc + 1;
         if (sel == 0) sb0.push_back(e);
         else          sb1.push_back(e);
      end
      @(negedge CLK);
      bit_vld[sel]     = 1'b0;
      sampled_bit[sel] = 1'($urandom);
   endtask

   task automatic drain();
      repeat (3) @(negedge CLK);
      check("drain", (sel == 0) ? sb0.size() : sb1.size(), 32'd0);
   endtask

   task automatic send_frame(input logic [7:0] d, input bit pen, input bit ptyp, input logic pbit,
                             input logic s0, input logic s1, input logic st, input int gap,
                             input bit mid_fs, input bit fs_bv);
      exp_t e;
      int   nstop;
      logic par_ok;
      nstop = (sel == 0) ? 1 : 2;
      frm_start[sel] = 1'b1;
      par_en[sel]    = pen;
      par_typ[sel]   = ptyp;
      if (fs_bv) begin
         bit_vld[sel]     = 1'b1;
         sampled_bit[sel] = 1'b1;
      end
      @(negedge CLK);
      frm_start[sel] = 1'b0;
      bit_vld[sel]   = 1'b0;
      // Flip the live settings: only the captured ones may matter.
      par_en[sel]    = ~pen;
      par_typ[sel]   = ~ptyp;
      check("busy_start", 32'(busy[sel]), 32'd1);
      if (st != 1'b0) begin
         e = '{dv: 1'b0, sg: 1'b1, pe: 1'b0, se: 1'b0, pd: last_good[sel], cyc: 0};
         send_bit(st, gap, 1'b1, e);
         check("busy_glitch", 32'(busy[sel]), 32'd0);
         drain();
         return;
      end
      // Even parity: bit makes the total count of ones even; odd: makes it odd.
      par_ok = ptyp ? ~^d : ^d;
      e.pe   = pen && (pbit != par_ok);
      e.se   = (s0 != 1'b1) || (nstop == 2 && s1 != 1'b1);
      e.sg   = 1'b0;
      e.dv   = !e.pe && !e.se;
      e.pd   = e.dv ? d : last_good[sel];
      e.cyc  = 0;
      if (e.dv) last_good[sel] = d;
      send_bit(1'b0, gap, 1'b0, e);
      for (int i = 0; i < 8; i++) begin
         if (mid_fs && i == 4) begin
            frm_start[sel] = 1'b1;
            @(negedge CLK);
            frm_start[sel] = 1'b0;
         end
         send_bit(d[i], gap, 1'b0, e);
      end
      if (pen) send_bit(pbit, gap, 1'b0, e);
      send_bit(s0, gap, nstop == 1, e);
      if (nstop == 2) send_bit(s1, gap, 1'b1, e);
      check("busy_end", 32'(busy[sel]), 32'd0);
      drain();
   endtask

   task automatic check_reset_state();
      for (int d = 0; d < 2; d++) begin
         check("rst_p_data",      32'(p_data[d]),      32'd0);
         check("rst_data_vld",    32'(data_vld[d]),    32'd0);
         check("rst_strt_glitch", 32'(strt_glitch[d]), 32'd0);
         check("rst_par_err",     32'(par_err[d]),     32'd0);
         check("rst_stop_err",    32'(stop_err[d]),    32'd0);
         check("rst_busy",        32'(busy[d]),        32'd0);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      RST         = 1'b1;
      frm_start   = '0;
      bit_vld     = '0;
      sampled_bit = '0;
      par_en      = '0;
      par_typ     = '0;
      last_good   = '0;
      sel         = 0;
      repeat (3) @(negedge CLK);
      check_reset_state();
      RST = 1'b0;
      @(negedge CLK);

      // Clean frame, no parity.
      send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
      // Even parity with wrong bit, then correct even and odd parity.
      send_frame(8'h5A, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
      send_frame(8'hC3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
      send_frame(8'h5A, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
      // Start-bit glitch.
      send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0);
      // Single stop bit wrong.
      send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0);

      // Two stop bits: second one bad, then first one bad, then clean.
      sel = 1;
      send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
      send_frame(8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2, 1'b0, 1'b0);

      // Reset in the middle of a frame, then a clean frame.
      sel = 0;
      frm_start[0] = 1'b1;
      @(negedge CLK);
      frm_start[0] = 1'b0;
      for (int i = 0; i < 5; i++) begin
         bit_vld[0]     = 1'b1;
         sampled_bit[0] = (i == 0) ? 1'b0 : 1'b1;
         @(negedge CLK);
         bit_vld[0] = 1'b0;
      end
      check("busy_mid", 32'(busy[0]), 32'd1);
      RST = 1'b1;
      @(negedge CLK);
      check_reset_state();
      RST       = 1'b0;
      last_good = '0;
      @(negedge CLK);
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);

      // frm_start mid-DATA and together with bit_vld in IDLE, with gaps up to 15 cycles.
      send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 15, 1'b1, 1'b1);

      // Random frames on both instances.
      for (int k = 0; k < 8; k++) begin
         sel = k % 2;
         send_frame(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                    ($urandom_range(3, 0) != 0), ($urandom_range(3, 0) != 0),
                    ($urandom_range(7, 0) == 0), 3, 1'($urandom), 1'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
